// File: rtl/route_test_pkg.sv
// route_test_pkg
// Shared definitions for on-hardware routing loop testers: the tester FSM
// state encoding, the 16-bit Fibonacci LFSR geometry (taps 16,14,13,11) and
// the saturation limit of the error counter.
// No ports (package).
package route_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LFSR_W = 16;

  // Zero-based bit indices of polynomial taps 16, 14, 13 and 11.
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  // One step of the LFSR: shift left, feedback enters bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/route_lfsr16.sv
// route_lfsr16
// 16-bit Fibonacci LFSR with synchronous load of SEED and an advance enable.
// Only the low OUT_W bits are exported so callers driving narrow stimulus do
// not carry unused high bits.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (loads SEED)
//   load     in   reload SEED (priority over advance)
//   advance  in   step the sequence by one
//   word     out  low OUT_W bits of the current LFSR value
module route_lfsr16
  import route_test_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [OUT_W-1:0] word
);

  logic [LFSR_W-1:0] value;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      value <= SEED;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

  assign word = value[OUT_W-1:0];

endmodule

// File: rtl/route_loop_tester.sv
// route_loop_tester
// Stimulus/check stage for routing fuzz verification. Sends num_words LFSR
// words into a routed path, compares the looped-back data after LAT cycles
// against a delayed copy of what was sent, and reports a saturating error
// count and a pass flag.
//
// Optional feature: define ROUTE_LOOP_LANE_MASK_EN to add the lane_err output,
// a sticky per-lane record of which lanes ever mismatched during a run.
//
// Ports:
//   clk        in   sole clock
//   rst        in   synchronous active-high reset; aborts a run, no done pulse
//   start      in   run request, accepted only in IDLE or DONE
//   num_words  in   words to send, sampled on accepted start
//   loop_in    in   data returned by the path under test
//   stim_out   out  stimulus, LFSR low bits in RUN, else 0
//   busy       out  high in RUN and DRAIN
//   done       out  one-cycle pulse on entering DONE
//   pass       out  in DONE: err_count == 0
//   err_count  out  mismatched words, saturating at 16'hFFFF
//   lane_err   out  (ROUTE_LOOP_LANE_MASK_EN only) sticky per-lane mismatch
//
// Handshake: start is a level sampled at posedge; it is acted on only in IDLE
// or DONE, otherwise dropped. There is no back-pressure on either side.
module route_loop_tester
  import route_test_pkg::*;
#(
  parameter int          WIDTH = 2,
  parameter int          LAT   = 1,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_words,
  input  logic [WIDTH-1:0] loop_in,
  output logic [WIDTH-1:0] stim_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count
`ifdef ROUTE_LOOP_LANE_MASK_EN
  ,
  output logic [WIDTH-1:0] lane_err
`endif
);

  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

  state_t            state;
  state_t            next_state;

  logic [15:0]       nw_q;
  logic [15:0]       sent_q;
  logic [DW-1:0]     drain_q;
  logic [15:0]       err_q;
  logic              done_q;

  logic              valid_pipe [LAT];
  logic [WIDTH-1:0]  data_pipe  [LAT];

  logic [WIDTH-1:0]  lfsr_word;
  logic [WIDTH-1:0]  run_word;
  logic              accept_start;
  logic              enter_done;
  logic              compare_en;
  logic              mismatch;

  assign accept_start = start && ((state == IDLE) || (state == DONE));

  route_lfsr16 #(
    .SEED  (SEED),
    .OUT_W (WIDTH)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept_start),
    .advance (state == RUN),
    .word    (lfsr_word)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = (num_words == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (sent_q == nw_q - 16'd1) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A zero-length restart from DONE stays in DONE but must pulse done again.
  assign enter_done = ((state != DONE) && (next_state == DONE)) ||
                      ((state == DONE) && accept_start);

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run_word  = '0;
    busy      = 1'b0;
    pass      = 1'b0;
    if (state == RUN) begin
      run_word = lfsr_word;
    end
    if ((state == RUN) || (state == DRAIN)) begin
      busy = 1'b1;
    end
    if ((state == DONE) && (err_q == 16'd0)) begin
      pass = 1'b1;
    end
  end

  assign stim_out  = run_word;
  assign done      = done_q;
  assign err_count = err_q;

  // ---------------- expected pipe and compare ----------------
  // The compare uses loop_in of the same cycle as the pipe output; the path
  // delay is matched entirely by the LAT-deep pipe.
  assign compare_en = ((state == RUN) || (state == DRAIN)) && valid_pipe[LAT-1];
  // Case inequality so an unknown lane in simulation counts as a mismatch.
  assign mismatch   = compare_en && (loop_in !== data_pipe[LAT-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      nw_q    <= '0;
      sent_q  <= '0;
      drain_q <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        valid_pipe[i] <= 1'b0;
        data_pipe[i]  <= '0;
      end
    end else begin
      done_q <= enter_done;

      if (accept_start) begin
        nw_q   <= num_words;
        sent_q <= '0;
        err_q  <= '0;
      end else begin
        if (state == RUN) begin
          sent_q <= sent_q + 16'd1;
        end
        if (mismatch && (err_q != ERR_MAX)) begin
          err_q <= err_q + 16'd1;
        end
      end

      if (state == DRAIN) begin
        drain_q <= drain_q + 1'b1;
      end else begin
        drain_q <= '0;
      end

      // Outside RUN the pipe fills with invalid entries, which flushes it.
      valid_pipe[0] <= (state == RUN);
      data_pipe[0]  <= run_word;
      for (int i = 1; i < LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        data_pipe[i]  <= data_pipe[i-1];
      end
    end
  end

`ifdef ROUTE_LOOP_LANE_MASK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_err <= '0;
    end else if (accept_start) begin
      lane_err <= '0;
    end else if (compare_en) begin
      lane_err <= lane_err | (loop_in ^ data_pipe[LAT-1]);
    end
  end
`else
  // Per-lane diagnosis is compiled out; only the aggregate count exists.
`endif

endmodule

// File: tb/tb_route_loop_tester.sv
// tb_route_loop_tester
// Self-checking bench for route_loop_tester (WIDTH=2, LAT=1). A behavioural
// path model returns stim_out one cycle later, optionally with lane 1 stuck
// at 0 or with every lane inverted. Expected stimulus words come from an
// independent LFSR model and are queued when a run is started, then popped
// as the DUT presents each word. Build with +define+ROUTE_LOOP_LANE_MASK_EN
// to also check lane_err.
module tb_route_loop_tester;

  localparam int WIDTH = 2;
  localparam int LAT   = 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [15:0]      num_words;
  logic [WIDTH-1:0] loop_in;
  logic [WIDTH-1:0] stim_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
`ifdef ROUTE_LOOP_LANE_MASK_EN
  logic [WIDTH-1:0] lane_err;
`endif

  always #5 clk = ~clk;

  route_loop_tester #(
    .WIDTH (WIDTH),
    .LAT   (LAT),
    .SEED  (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .loop_in   (loop_in),
    .stim_out  (stim_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count)
`ifdef ROUTE_LOOP_LANE_MASK_EN
    ,
    .lane_err  (lane_err)
`endif
  );

  // ---------------- path under test model ----------------
  // mode 0: clean loopback, 1: lane 1 stuck at 0, 2: all lanes inverted.
  int               mode;
  logic [WIDTH-1:0] loop_reg;

  function automatic logic [WIDTH-1:0] path_out(input int m, input logic [WIDTH-1:0] w);
    case (m)
      1:       return w & 2'b01;
      2:       return ~w;
      default: return w;
    endcase
  endfunction

  always @(posedge clk) loop_reg <= stim_out;
  always_comb loop_in = path_out(mode, loop_reg);

  function automatic logic [15:0] lfsr_model(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Runs one test of n words through path mode m. If poke >= 0, a second
  // start is pulsed during word index poke and must be ignored.
  task automatic run_test(input int n, input int m, input int poke);
    logic [15:0]      l;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] obs;
    logic [WIDTH-1:0] exp_lane;
    int               exp_err;
    l        = 16'hACE1;
    exp_err  = 0;
    exp_lane = '0;
    mode     = m;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      w   = l[WIDTH-1:0];
      obs = path_out(m, w);
      exp_q.push_back(w);
      if (obs != w) begin
        if (exp_err < 65535) exp_err++;
        exp_lane = exp_lane | (obs ^ w);
      end
      l = lfsr_model(l);
    end

    @(negedge clk);
    start     = 1'b1;
    num_words = n[15:0];
    @(negedge clk);
    start     = 1'b0;
    // Only the value at the accepting edge may matter from here on.
    num_words = 16'($urandom_range(0, 65535));

    if (n > 0) begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        if (i == poke) begin
          start     = 1'b1;
          num_words = 16'd2;
        end else begin
          start = 1'b0;
        end
        check("stim", 32'(stim_out), 32'(exp_q.pop_front()));
        check("busy_run", 32'(busy), 32'd1);
      end
      start = 1'b0;
      for (int d = 0; d < LAT; d++) begin
        @(negedge clk);
        check("stim_drain", 32'(stim_out), 32'd0);
        check("busy_drain", 32'(busy), 32'd1);
        check("done_early", 32'(done), 32'd0);
      end
      @(negedge clk);
    end

    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("pass", 32'(pass), 32'(exp_err == 0));
    check("err_count", 32'(err_count), 32'(exp_err));
`ifdef ROUTE_LOOP_LANE_MASK_EN
    check("lane_err", 32'(lane_err), 32'(exp_lane));
`endif
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("pass_hold", 32'(pass), 32'(exp_err == 0));
    check("err_hold", 32'(err_count), 32'(exp_err));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    num_words = 16'd0;
    mode      = 0;
    repeat (3) @(negedge clk);
    check("rst_stim", 32'(stim_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
`ifdef ROUTE_LOOP_LANE_MASK_EN
    check("rst_lane", 32'(lane_err), 32'd0);
`endif
    rst = 1'b0;

    run_test(8, 0, -1);       // clean loopback, word0 = 2'b01
    run_test(0, 0, -1);       // zero-length run
    run_test(16, 1, -1);      // lane 1 stuck at 0

    // Reset in the middle of a run.
    mode = 0;
    @(negedge clk);
    start     = 1'b1;
    num_words = 16'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_stim", 32'(stim_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_err", 32'(err_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_idle_done", 32'(done), 32'd0);
      check("abort_idle_busy", 32'(busy), 32'd0);
    end
    run_test(4, 0, -1);

    run_test(6, 2, -1);       // errors, then restart from DONE clears them
    run_test(10, 0, 3);       // start pulsed during RUN is ignored
    run_test(65535, 2, -1);   // every word wrong, count pins at 16'hFFFF
    run_test(0, 0, -1);       // zero-length restart from DONE after errors

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
